lcd_msg_driver: RTL and testbench
=================================

LCD_MSG_DRIVER -- requirements
Module: lcd_msg_driver

Interface
REQ-001 SHALL have parameter T_PWR, default 750000, power-up wait in CLK cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameter T_EN, default 25, LCD_E high width in cycles.
REQ-003 SHALL have parameter T_CMD, default 2500, post-write wait in cycles for all writes except clear.
REQ-004 SHALL have parameter T_CLR, default 100000, post-write wait in cycles after the clear command.
REQ-005 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port dispMsg, input, [0:511], 64 characters; char i is dispMsg[8i:8i+7]; bit 7 of a char is the cursor marker.
REQ-008 SHALL have port LCD_DB, output, 8, HD44780 data bus.
REQ-009 SHALL have port LCD_RS, output, 1: 0 = command, 1 = data.
REQ-010 SHALL have port LCD_RW, output, 1, constant 0.
REQ-011 SHALL have port LCD_E, output, 1, enable strobe.
REQ-012 SHALL have port BUSY, output, 1, high whenever the FSM is not in IDLE.
REQ-013 SHALL have port FRAME_DONE, output, 1, one-cycle pulse when a frame completes.

Function
REQ-014 Each byte write SHALL take 1 setup cycle (RS/DB valid, E low), then T_EN cycles E high, then T_CMD (or T_CLR) cycles E low; RS/DB held stable throughout.
REQ-015 FSM states SHALL be PWR_WAIT, INIT, IDLE, ROW_ADDR, CHAR, CURSOR, DISP_CTRL.
REQ-016 PWR_WAIT SHALL count T_PWR cycles, then go to INIT.
REQ-017 INIT SHALL write commands 0x38, 0x08, 0x01 (T_CLR wait), 0x06 in order, then go to IDLE with the shown-copy register cleared to all zero.
REQ-018 IDLE SHALL start a frame when dispMsg differs from the shown-copy; at frame start dispMsg SHALL be snapshotted into both the working copy and the shown-copy.
REQ-019 For row r = 0..3 the frame SHALL write command 0x80|base[r], with base = {0x00, 0x40, 0x10, 0x50}, followed by 16 data writes of chars 16r..16r+15 with bit 7 forced to 0.
REQ-020 Cursor target SHALL be the lowest index i with bit 7 set in the snapshot; its address SHALL be base[i/16] + i%16.
REQ-021 If a target exists, the frame SHALL write command 0x80|address in CURSOR, then 0x0D in DISP_CTRL; otherwise CURSOR SHALL be skipped and DISP_CTRL SHALL write 0x0C.
REQ-022 After DISP_CTRL, FRAME_DONE SHALL pulse and the FSM SHALL return to IDLE; a frame is 70 writes with a cursor target, 69 without.
REQ-023 dispMsg changes mid-frame SHALL NOT affect the frame in progress; a difference still present at IDLE SHALL start a new frame in the next cycle.
REQ-024 Wait counters SHALL be sized for the largest parameter and SHALL NOT wrap.

Reset
REQ-025 On RESET_N low: LCD_E = 0, LCD_RS = 0, LCD_DB = 0x00, BUSY = 1, FRAME_DONE = 0, FSM = PWR_WAIT, all counters 0, copies cleared; this SHALL take effect immediately, including mid-write.
REQ-026 Release of RESET_N SHALL restart the full power-up sequence.

Structure
REQ-027 A shared package lcd_pkg SHALL hold the state enum, command constants (0x38, 0x08, 0x01, 0x06, 0x0C, 0x0D, 0x80) and the row base table.
REQ-028 Sub-module lcd_byte_writer SHALL implement REQ-014 with a start/done handshake: start is accepted only when idle; done pulses one cycle after the wait ends.

Verification (T_PWR=10, T_EN=2, T_CMD=4, T_CLR=8)
REQ-029 Reset release -> E low for 10 cycles, then 0x38/0x08/0x01/0x06 with RS=0, gap after 0x01 of 8 cycles, each E pulse exactly 2 cycles.
REQ-030 All chars 0x41 -> 64 data writes of 0x41 after row commands 0x80/0xC0/0x90/0xD0, final 0x0C, FRAME_DONE once, 69 writes.
REQ-031 Char 0 = 0xA0, others 0x20 -> char 0 sent as 0x20, then 0x80, then 0x0D.
REQ-032 Chars 20 and 40 marked -> cursor command 0xC4 (char 20 wins).
REQ-033 dispMsg changed during the row-2 writes -> current frame shows the old data, a second frame starts the cycle after FRAME_DONE.
REQ-034 RESET_N pulsed low while E is high -> E falls asynchronously and the sequence restarts at PWR_WAIT.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and DDRAM row addressing for the LCD message driver.
package lcd_pkg;

    localparam int unsigned N_CHARS = 64;
    localparam int unsigned MSG_W   = N_CHARS * 8;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        ROW_ADDR,
        CHAR,
        CURSOR,
        DISP_CTRL
    } lcd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_EN_HIGH,
        WR_HOLD
    } wr_state_t;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } cursor_t;

    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_DISP_OFF  = 8'h08;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_DISP_CUR  = 8'h0D;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    // Rows 2/3 of a 16x4 panel continue rows 0/1 at +0x10.
    function automatic logic [7:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h10;
            default: return 8'h50;
        endcase
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_OFF;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY;
        endcase
    endfunction

    // Lowest character index whose bit 7 (cursor marker) is set.
    function automatic cursor_t find_cursor(input logic [0:MSG_W-1] msg);
        cursor_t c;
        c = '0;
        for (int i = int'(N_CHARS) - 1; i >= 0; i--) begin
            if (msg[{6'(i), 3'b000}]) begin
                c.found = 1'b1;
                c.idx   = 6'(i);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 bus write: setup cycle, E high for T_EN, then E low for T_CMD or T_CLR.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_EN  = 25,
    parameter int unsigned T_CMD = 2500,
    parameter int unsigned T_CLR = 100000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] db,
    input  logic       long_wait,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_db
);

    localparam int unsigned T_MAX_A = (T_EN > T_CMD) ? T_EN : T_CMD;
    localparam int unsigned T_MAX   = (T_MAX_A > T_CLR) ? T_MAX_A : T_CLR;
    localparam int unsigned CNT_W   = $clog2(T_MAX + 1);

    wr_state_t        wr_state;
    logic [CNT_W-1:0] cnt;
    logic             long_q;
    logic [CNT_W-1:0] hold_last_c;

    assign hold_last_c = long_q ? CNT_W'(T_CLR - 1) : CNT_W'(T_CMD - 1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_state <= WR_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            done     <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_db   <= '0;
        end else begin
            done <= 1'b0;
            case (wr_state)
                WR_IDLE: begin
                    if (start) begin
                        lcd_rs   <= rs;
                        lcd_db   <= db;
                        long_q   <= long_wait;
                        wr_state <= WR_SETUP;
                    end
                end
                WR_SETUP: begin
                    lcd_e    <= 1'b1;
                    cnt      <= '0;
                    wr_state <= WR_EN_HIGH;
                end
                WR_EN_HIGH: begin
                    if (cnt == CNT_W'(T_EN - 1)) begin
                        lcd_e    <= 1'b0;
                        cnt      <= '0;
                        wr_state <= WR_HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR_HOLD: begin
                    if (cnt == hold_last_c) begin
                        cnt      <= '0;
                        done     <= 1'b1;
                        wr_state <= WR_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_msg_driver.sv
// Initialises an HD44780 16x4 LCD and repaints all 64 characters plus cursor whenever dispMsg changes.
module lcd_msg_driver
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWR = 750000,
    parameter int unsigned T_EN  = 25,
    parameter int unsigned T_CMD = 2500,
    parameter int unsigned T_CLR = 100000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [0:MSG_W-1] dispMsg,
    output logic [7:0]       LCD_DB,
    output logic             LCD_RS,
    output logic             LCD_RW,
    output logic             LCD_E,
    output logic             BUSY,
    output logic             FRAME_DONE
);

    localparam int unsigned PWR_W = $clog2(T_PWR + 1);

    lcd_state_t       state;
    logic [PWR_W-1:0] pwr_cnt;
    logic [1:0]       step;
    logic [1:0]       row;
    logic [3:0]       col;
    logic             issued;
    logic             wr_start;
    logic             wr_done;
    logic [0:MSG_W-1] work;
    logic [0:MSG_W-1] shown;

    cursor_t          cur_c;
    logic [6:0]       ch_low_c;
    logic             wr_rs_c;
    logic [7:0]       wr_db_c;
    logic             wr_long_c;

    assign LCD_RW = 1'b0;
    assign cur_c  = find_cursor(work);

    // Byte for the write owned by the current state; stable until that write completes.
    always_comb begin
        ch_low_c  = work[{row, col, 3'b001} +: 7];
        wr_rs_c   = 1'b0;
        wr_db_c   = '0;
        wr_long_c = 1'b0;
        case (state)
            INIT: begin
                wr_db_c   = init_cmd(step);
                wr_long_c = (step == 2'd2);
            end
            ROW_ADDR:  wr_db_c = CMD_SET_DDRAM | row_base(row);
            CHAR: begin
                wr_rs_c = 1'b1;
                wr_db_c = {1'b0, ch_low_c};
            end
            CURSOR:    wr_db_c = CMD_SET_DDRAM | row_base(cur_c.idx[5:4]) | {4'h0, cur_c.idx[3:0]};
            DISP_CTRL: wr_db_c = cur_c.found ? CMD_DISP_CUR : CMD_DISP_ON;
            default:   ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= PWR_WAIT;
            pwr_cnt    <= '0;
            step       <= '0;
            row        <= '0;
            col        <= '0;
            issued     <= 1'b0;
            wr_start   <= 1'b0;
            work       <= '0;
            shown      <= '0;
            BUSY       <= 1'b1;
            FRAME_DONE <= 1'b0;
        end else begin
            wr_start   <= 1'b0;
            FRAME_DONE <= 1'b0;
            if (state inside {INIT, ROW_ADDR, CHAR, CURSOR, DISP_CTRL} && !issued) begin
                wr_start <= 1'b1;
                issued   <= 1'b1;
            end
            case (state)
                PWR_WAIT: begin
                    if (pwr_cnt == PWR_W'(T_PWR - 1)) begin
                        pwr_cnt <= '0;
                        state   <= INIT;
                    end else begin
                        pwr_cnt <= pwr_cnt + PWR_W'(1);
                    end
                end
                INIT: begin
                    if (wr_done) begin
                        issued <= 1'b0;
                        if (step == 2'd3) begin
                            step  <= '0;
                            shown <= '0;
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            step <= step + 2'd1;
                        end
                    end
                end
                IDLE: begin
                    if (dispMsg != shown) begin
                        work  <= dispMsg;
                        shown <= dispMsg;
                        row   <= '0;
                        col   <= '0;
                        BUSY  <= 1'b1;
                        state <= ROW_ADDR;
                    end
                end
                ROW_ADDR: begin
                    if (wr_done) begin
                        issued <= 1'b0;
                        col    <= '0;
                        state  <= CHAR;
                    end
                end
                CHAR: begin
                    if (wr_done) begin
                        issued <= 1'b0;
                        col    <= col + 4'd1;
                        if (col == 4'd15) begin
                            row <= row + 2'd1;
                            if (row == 2'd3) begin
                                state <= cur_c.found ? CURSOR : DISP_CTRL;
                            end else begin
                                state <= ROW_ADDR;
                            end
                        end
                    end
                end
                CURSOR: begin
                    if (wr_done) begin
                        issued <= 1'b0;
                        state  <= DISP_CTRL;
                    end
                end
                DISP_CTRL: begin
                    if (wr_done) begin
                        issued     <= 1'b0;
                        FRAME_DONE <= 1'b1;
                        BUSY       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

    lcd_byte_writer #(
        .T_EN  (T_EN),
        .T_CMD (T_CMD),
        .T_CLR (T_CLR)
    ) u_writer (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .start     (wr_start),
        .rs        (wr_rs_c),
        .db        (wr_db_c),
        .long_wait (wr_long_c),
        .done      (wr_done),
        .lcd_e     (LCD_E),
        .lcd_rs    (LCD_RS),
        .lcd_db    (LCD_DB)
    );

endmodule

// File: tb/tb_lcd_msg_driver.sv
// Directed bench for lcd_msg_driver: bus-level write log compared against hand-built expected frames.
module tb_lcd_msg_driver;

    localparam int unsigned T_PWR = 10;
    localparam int unsigned T_EN  = 2;
    localparam int unsigned T_CMD = 4;
    localparam int unsigned T_CLR = 8;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic [0:511] dispMsg;
    logic [7:0]   LCD_DB;
    logic         LCD_RS;
    logic         LCD_RW;
    logic         LCD_E;
    logic         BUSY;
    logic         FRAME_DONE;

    lcd_msg_driver #(
        .T_PWR (T_PWR),
        .T_EN  (T_EN),
        .T_CMD (T_CMD),
        .T_CLR (T_CLR)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .dispMsg    (dispMsg),
        .LCD_DB     (LCD_DB),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_E      (LCD_E),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         fd_count = 0;
    int         rise_cyc = 0;
    bit         mon_en = 1'b0;
    logic       e_q = 1'b0;
    logic [8:0] held = '0;
    logic [8:0] log_w[$];
    int         rise_q[$];
    int         fall_q[$];
    logic [7:0] row_cmd[4] = '{8'h80, 8'hC0, 8'h90, 8'hD0};
    logic [7:0] init_exp[4] = '{8'h38, 8'h08, 8'h01, 8'h06};

    typedef struct {
        string      name;
        logic [7:0] fill;
        logic [7:0] ch0;
        int         mark_a;
        int         mark_b;
        logic [7:0] exp_cur;
        logic [7:0] exp_ctrl;
        int         exp_n;
    } frame_vec_t;

    frame_vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Bus monitor: logs each write at the E rising edge and checks pulse width and hold stability.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (LCD_E && !e_q) begin
                log_w.push_back({LCD_RS, LCD_DB});
                rise_q.push_back(cyc);
                rise_cyc = cyc;
                held = {LCD_RS, LCD_DB};
            end else if (LCD_E && e_q) begin
                chk("rs_db_stable", 32'({LCD_RS, LCD_DB}), 32'(held));
            end else if (!LCD_E && e_q) begin
                fall_q.push_back(cyc);
                chk("e_width", 32'(cyc - rise_cyc), 32'(T_EN));
            end
            if (FRAME_DONE) fd_count++;
        end
        e_q = LCD_E;
    end

    function automatic logic [0:511] make_msg(input logic [7:0] fill, input logic [7:0] ch0,
                                              input int ma, input int mb);
        logic [0:511] m;
        logic [7:0]   b;
        for (int i = 0; i < 64; i++) begin
            b = (i == 0) ? ch0 : fill;
            if (i == ma || i == mb) b[7] = 1'b1;
            m[9'(i * 8) +: 8] = b;
        end
        return m;
    endfunction

    task automatic clear_log();
        log_w.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    task automatic check_init(input string nm, input int rel);
        int d;
        int g0;
        int g1;
        int g2;
        for (int k = 0; k < 500 && log_w.size() < 4; k++) begin
            @(posedge CLK); #1;
        end
        chk({nm, "_count"}, 32'(log_w.size() >= 4), 32'd1);
        if (log_w.size() >= 4 && fall_q.size() >= 3) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("%s_cmd%0d", nm, i), 32'(log_w[i]), 32'({1'b0, init_exp[i]}));
            d  = rise_q[0] - rel;
            chk({nm, "_pwr_wait"}, 32'(d >= int'(T_PWR) && d <= int'(T_PWR) + 5), 32'd1);
            g0 = rise_q[1] - fall_q[0];
            g1 = rise_q[2] - fall_q[1];
            g2 = rise_q[3] - fall_q[2];
            chk({nm, "_gap_min"}, 32'(g0 >= int'(T_CMD) + 1), 32'd1);
            chk({nm, "_gap_cmd_equal"}, 32'(g1), 32'(g0));
            chk({nm, "_gap_clear_extra"}, 32'(g2 - g0), 32'(T_CLR - T_CMD));
        end
    endtask

    task automatic run_frame(input string nm, input logic [0:511] m, input logic [7:0] exp_cur,
                             input logic [7:0] exp_ctrl, input int exp_n, input int chg_at,
                             input logic [0:511] m2, input logic busy_after);
        logic [8:0] exp_q[$];
        logic [7:0] b;
        int         fd0;
        bit         changed;
        changed = 1'b0;
        for (int r = 0; r < 4; r++) begin
            exp_q.push_back({1'b0, row_cmd[r]});
            for (int c = 0; c < 16; c++) begin
                b = m[9'((16 * r + c) * 8) +: 8];
                exp_q.push_back({2'b10, b[6:0]});
            end
        end
        if (exp_cur != 8'h00) exp_q.push_back({1'b0, exp_cur});
        exp_q.push_back({1'b0, exp_ctrl});

        clear_log();
        fd0 = fd_count;
        dispMsg = m;
        @(posedge CLK); #1;
        chk({nm, "_busy_start"}, 32'(BUSY), 32'd1);
        for (int k = 0; k < 3000; k++) begin
            if (FRAME_DONE) break;
            @(posedge CLK); #1;
            if (chg_at >= 0 && !changed && log_w.size() >= chg_at) begin
                dispMsg = m2;
                changed = 1'b1;
            end
        end
        chk({nm, "_frame_done"}, 32'(FRAME_DONE), 32'd1);
        @(posedge CLK); #1;
        chk({nm, "_busy_after"}, 32'(BUSY), 32'(busy_after));
        chk({nm, "_done_pulses"}, 32'(fd_count - fd0), 32'd1);
        chk({nm, "_writes"}, 32'(log_w.size()), 32'(exp_n));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_wr%0d", nm, i),
                (i < log_w.size()) ? 32'(log_w[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    initial begin
        int           rel;
        logic [0:511] m1;
        logic [0:511] m2;
        logic [0:511] m3;

        vecs[0] = '{"all_A",    8'h41, 8'h41, -1, -1, 8'h00, 8'h0C, 69};
        vecs[1] = '{"cur0",     8'h20, 8'hA0, -1, -1, 8'h80, 8'h0D, 70};
        vecs[2] = '{"cur20_40", 8'h2E, 8'h2E, 20, 40, 8'hC4, 8'h0D, 70};
        vecs[3] = '{"cur63",    8'h30, 8'h30, 63, -1, 8'hDF, 8'h0D, 70};
        vecs[4] = '{"cur31_16", 8'h7E, 8'h7E, 31, 16, 8'hC0, 8'h0D, 70};
        vecs[5] = '{"cur47",    8'h55, 8'h55, 47, -1, 8'h9F, 8'h0D, 70};

        RESET_N = 1'b0;
        dispMsg = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_e",    32'(LCD_E),      32'd0);
        chk("rst_rs",   32'(LCD_RS),     32'd0);
        chk("rst_db",   32'(LCD_DB),     32'd0);
        chk("rst_rw",   32'(LCD_RW),     32'd0);
        chk("rst_busy", 32'(BUSY),       32'd1);
        chk("rst_fd",   32'(FRAME_DONE), 32'd0);

        clear_log();
        mon_en  = 1'b1;
        RESET_N = 1'b1;
        rel     = cyc;
        check_init("init", rel);

        // An all-zero message matches the cleared shown copy, so no frame may start.
        repeat (40) @(posedge CLK);
        #1;
        chk("idle_busy",   32'(BUSY),         32'd0);
        chk("idle_writes", 32'(log_w.size()), 32'd4);

        for (int v = 0; v < 6; v++)
            run_frame(vecs[v].name,
                      make_msg(vecs[v].fill, vecs[v].ch0, vecs[v].mark_a, vecs[v].mark_b),
                      vecs[v].exp_cur, vecs[v].exp_ctrl, vecs[v].exp_n, -1, '0, 1'b0);

        // Message replaced while row 2 is being written.
        m1 = make_msg(8'h61, 8'h61, -1, -1);
        m2 = make_msg(8'h62, 8'h62, -1, -1);
        run_frame("midchg_old", m1, 8'h00, 8'h0C, 69, 35, m2, 1'b1);
        run_frame("midchg_new", m2, 8'h00, 8'h0C, 69, -1, '0, 1'b0);

        // Asynchronous reset in the middle of an E-high phase.
        m3 = make_msg(8'h33, 8'h33, 5, -1);
        dispMsg = m3;
        for (int k = 0; k < 200; k++) begin
            @(posedge CLK); #1;
            if (LCD_E) break;
        end
        chk("arst_e_high_seen", 32'(LCD_E), 32'd1);
        mon_en = 1'b0;
        #3;
        RESET_N = 1'b0;
        #1;
        chk("arst_e",    32'(LCD_E),  32'd0);
        chk("arst_db",   32'(LCD_DB), 32'd0);
        chk("arst_rs",   32'(LCD_RS), 32'd0);
        chk("arst_busy", 32'(BUSY),   32'd1);
        repeat (2) @(posedge CLK);
        #1;
        clear_log();
        mon_en  = 1'b1;
        RESET_N = 1'b1;
        rel     = cyc;
        check_init("reinit", rel);
        run_frame("after_reset", m3, 8'h85, 8'h0D, 70, -1, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
